// File: rtl/bit_scan_unit.sv
// Bit scan unit: iterative find-first-one / find-last-one over a 32-bit word, one nibble per cycle.
// Define BIT_SCAN_EARLY_EXIT_EN to finish on the first hit; otherwise every scan takes 8 cycles.
module bit_scan_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        control,
  input  logic [31:0] operantA,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] op_q;
  logic        mode_q;
  logic [2:0]  ptr_q;
  logic        hit_q;
  logic [5:0]  hit_val_q;
  logic [5:0]  res_q;

  logic [3:0]  nib;
  logic [1:0]  pos;
  logic        nib_hit;
  logic [5:0]  nib_val;
  logic        last_nib;
  logic        accept;
  logic        scan_end;
  logic [5:0]  first_val;

  // Handshake: start is taken on a rising edge only when busy=0 (IDLE or DONE);
  // done is a one-cycle strobe and result is valid from that cycle until the next done.
  assign nib      = op_q[{ptr_q, 2'b00} +: 4];
  assign nib_hit  = |nib;
  assign nib_val  = {1'b0, ptr_q, pos} + 6'd1;
  assign last_nib = mode_q ? (ptr_q == 3'd0) : (ptr_q == 3'd7);

  always_comb begin
    pos = 2'd0;
    if (!mode_q) begin
      if (nib[0])      pos = 2'd0;
      else if (nib[1]) pos = 2'd1;
      else if (nib[2]) pos = 2'd2;
      else             pos = 2'd3;
    end else begin
      if (nib[3])      pos = 2'd3;
      else if (nib[2]) pos = 2'd2;
      else if (nib[1]) pos = 2'd1;
      else             pos = 2'd0;
    end
  end

  // An earlier hit always wins; the current nibble only counts if nothing was found yet.
  assign first_val = hit_q ? hit_val_q : (nib_hit ? nib_val : 6'd0);
  assign accept    = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    scan_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
`ifdef BIT_SCAN_EARLY_EXIT_EN
        scan_end = nib_hit || last_nib;
`else
        scan_end = last_nib;
`endif
        if (scan_end) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q      <= 32'd0;
      mode_q    <= 1'b0;
      ptr_q     <= 3'd0;
      hit_q     <= 1'b0;
      hit_val_q <= 6'd0;
      res_q     <= 6'd0;
    end else if (accept) begin
      op_q      <= operantA;
      mode_q    <= control;
      ptr_q     <= control ? 3'd7 : 3'd0;
      hit_q     <= 1'b0;
      hit_val_q <= 6'd0;
    end else if (state == SCAN) begin
      ptr_q <= mode_q ? ptr_q - 3'd1 : ptr_q + 3'd1;
      if (!hit_q && nib_hit) begin
        hit_q     <= 1'b1;
        hit_val_q <= nib_val;
      end
      if (scan_end) res_q <= first_val;
    end
  end

  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign result    = {26'd0, res_q};
  assign fsm_state = state;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Randomized scoreboard bench for bit_scan_unit with directed corner cases and a bit-level reference model.
module tb_bit_scan_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        control = 1'b0;
  logic [31:0] operantA = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  fsm_state;

  bit_scan_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .control  (control),
    .operantA (operantA),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] held = 32'd0;
  logic [31:0] mon_res;
  int          mon_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d", name, act, act, expv, expv, cyc);
    end
  endtask

  // Reference: scan the bits directly, count nibbles touched for latency.
  function automatic void ref_scan(input logic mode, input logic [31:0] w,
                                   output logic [31:0] res, output int n);
    int idx;
    idx = -1;
    res = 32'd0;
    n   = 8;
    if (!mode) begin
      for (int i = 31; i >= 0; i--) if (w[i]) idx = i;
    end else begin
      for (int i = 0; i < 32; i++) if (w[i]) idx = i;
    end
    if (idx >= 0) begin
      res = 32'(idx + 1);
`ifdef BIT_SCAN_EARLY_EXIT_EN
      n = mode ? 8 - idx / 4 : idx / 4 + 1;
`endif
    end
  endfunction

  // Monitor: pops an expectation on every done strobe; between strobes result must hold.
  always @(negedge clock) begin
    if (!reset) begin
      held = 32'd0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_res = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("result", result, mon_res);
        check("done_cycle", cyc, mon_cyc);
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
      held = result;
    end else begin
      check("result_hold", result, held);
    end
  end

  // Driver: call at a negedge; start edge is the following posedge.
  task automatic issue(input logic mode, input logic [31:0] w);
    logic [31:0] res;
    int n;
    ref_scan(mode, w, res, n);
    start    = 1'b1;
    control  = mode;
    operantA = w;
    exp_q.push_back(res);
    exp_cyc_q.push_back(cyc + 1 + n);
    @(negedge clock);
    start    = 1'b0;
    control  = 1'($urandom_range(0, 1));
    operantA = $urandom;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] w;
    logic        m;
    // Reset phase, with start held high to show it is ignored
    reset    = 1'b0;
    start    = 1'b1;
    operantA = 32'h1;
    repeat (3) @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    check("start_in_reset_ignored", {31'd0, busy}, 32'd0);

    // Directed corners
    issue(1'b0, 32'h0000_0001); wait_drain();
    issue(1'b1, 32'h8000_0001); wait_drain();
    issue(1'b0, 32'h8000_0001); wait_drain();
    issue(1'b0, 32'h0000_0000); wait_drain();
    issue(1'b1, 32'h0000_0000); wait_drain();

    // Back-to-back: second start in the DONE cycle
    issue(1'b0, 32'h00F0_0000);
    wait_done();
    issue(1'b1, 32'h0000_0300);
    wait_drain();

    // Start during SCAN is ignored
    issue(1'b0, 32'h0001_0000);
    @(negedge clock);
    start    = 1'b1;
    control  = 1'b1;
    operantA = 32'hFFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    wait_drain();

    // Reset during SCAN aborts without a done strobe
    issue(1'b1, 32'h0000_0010);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clock);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    repeat (12) @(negedge clock);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: w = 32'd0;
        1: w = 32'd1 << $urandom_range(0, 31);
        2: w = $urandom & $urandom & $urandom;
        default: w = $urandom;
      endcase
      issue(m, w);
      if ($urandom_range(0, 1) == 1) begin
        start    = 1'b1;
        control  = 1'($urandom_range(0, 1));
        operantA = $urandom;
        @(negedge clock);
        start = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
      end else begin
        wait_drain();
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
    end
    wait_drain();
    repeat (4) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_scan_unit.md
BIT_SCAN_UNIT -- requirements
Module: bit_scan_unit

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset, sampled on rising clock.
REQ-003 SHALL have port start, input, 1, request pulse; accepted only while busy=0.
REQ-004 SHALL have port control, input, 1, scan mode: 0 = find-first-one (ff1, LSB upward), 1 = find-last-one (fl1, MSB downward).
REQ-005 SHALL have port operantA, input, 32, word to scan; sampled only on an accepted start.
REQ-006 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-007 SHALL have port done, output, 1, single-cycle completion strobe.
REQ-008 SHALL have port result, output, 32, scan result: bit index + 1 (1..32), or 0 if operand is zero; upper 26 bits always 0.

Function
REQ-009 SHALL implement a state machine with states IDLE, SCAN, DONE.
REQ-010 IDLE: busy=0, done=0; start=1 latches operantA and control and moves to SCAN; the nibble pointer is set to 0 for ff1 and to 7 for fl1.
REQ-011 SCAN: busy=1; each cycle examines exactly one nibble (bits 4k+3..4k); ff1 advances k upward and fl1 advances k downward.
REQ-012 Within a nonzero nibble, ff1 SHALL select the lowest set bit p and fl1 the highest; the hit value is 4k+p+1.
REQ-013 The first hit in scan order SHALL be the result; later nibbles never overwrite it.
REQ-014 When the last nibble (k=7 for ff1, k=0 for fl1) is examined with no prior hit, result SHALL be 0 and the state SHALL move to DONE.
REQ-015 DONE: busy=0 and done=1 for exactly one cycle; result is valid in this cycle; the next state is IDLE unless start=1.
REQ-016 start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back operation, no bubble cycle).
REQ-017 start while busy=1 SHALL be ignored, and operantA and control changes during SCAN SHALL have no effect.
REQ-018 result SHALL hold its value from DONE until the next DONE; it is not cleared on start.
REQ-019 Latency is measured from the start edge (cycle 0): SCAN occupies cycles 1..n and done is asserted in cycle n+1.

Reset
REQ-020 reset=0 at a rising edge SHALL force IDLE with busy=0, done=0, result=0, and the latched operand and pointer cleared.
REQ-021 Reset during SCAN or DONE SHALL abort the operation; no done strobe is issued for the aborted operation.
REQ-022 start while reset=0 SHALL be ignored.

Configuration
REQ-023 Macro BIT_SCAN_EARLY_EXIT_EN SHALL select the termination policy.
REQ-024 With BIT_SCAN_EARLY_EXIT_EN defined, SCAN SHALL move to DONE in the cycle that finds the first hit: n = number of nibbles examined (1..8).
REQ-025 Without BIT_SCAN_EARLY_EXIT_EN, SCAN SHALL always run 8 cycles (n=8, done in cycle 9), recording only the first hit: constant latency.
REQ-026 Result values SHALL be identical in both configurations.

Verification
REQ-027 ff1, operantA=0x00000001, start at cycle 0 -> result=1; done at cycle 2 with early exit, cycle 9 without.
REQ-028 fl1, operantA=0x80000001 -> result=32; done at cycle 2 with early exit; ff1 with the same operand -> result=1.
REQ-029 ff1 and fl1 with operantA=0x00000000 -> result=0, done at cycle 9 in both configurations.
REQ-030 ff1 with operantA=0x00F00000, then a second start during the DONE cycle using fl1 and operantA=0x00000300 -> results 21 then 10, with no idle cycle between operations.
REQ-031 fl1 with operantA=0x00000010, reset=0 asserted in cycle 3 -> busy=0, result=0, and no done pulse.
REQ-032 start pulsed again in cycle 2 with operantA=0xFFFFFFFF during an ff1 scan of 0x00010000 -> ignored; result=17.
